wr_resp_router: RTL and testbench

Parametrised write-channel return router for one master port of the AXI interconnect. It generalises the two-slave combinational return mux to NUM_SLV slaves with a per-slave grant code compared against this master's code. It adds an in-order outstanding-transaction queue, so W beats and B responses follow the slave chosen at AW handshake even after arbitration moves on. It sits between the slave-side arbiters and the master's AWREADY/WREADY/BVALID/BRESP return path.

---
 rtl/wr_resp_router.sv | 166 ++++++++++++++++
 tb/tb_wr_resp_router.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/wr_resp_router.sv
`default_nettype none
// ============================================================================
// Module      : wr_resp_router
// Description : Write-channel return router for one master port. The AW
//               handshake selects the slave whose grant code matches this
//               master's code. That slave index is queued in order, so that
//               W beats and B responses keep following the slave chosen at
//               AW time after arbitration has moved on.
// Revision    : 1.0 - initial release
// ============================================================================
module wr_resp_router #(
    parameter int                NUM_SLV  = 2,
    parameter int                SEL_W    = 2,
    parameter logic [SEL_W-1:0]  MAS_CODE = 2'b01,
    parameter int                DEPTH    = 4
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic                       mst_AWVALID,
    input  logic                       mst_WVALID,
    input  logic                       mst_WLAST,
    input  logic                       mst_BREADY,
    input  logic [NUM_SLV*SEL_W-1:0]   sl_mas_sel,
    input  logic [NUM_SLV-1:0]         s_AWREADY,
    input  logic [NUM_SLV-1:0]         s_WREADY,
    input  logic [NUM_SLV-1:0]         s_BVALID,
    input  logic [2*NUM_SLV-1:0]       s_BRESP,
    output logic                       wr_AWREADY,
    output logic                       wr_WREADY,
    output logic                       wr_BVALID,
    output logic [1:0]                 wr_BRESP,
    output logic [NUM_SLV-1:0]         slv_WSEL,
    output logic [NUM_SLV-1:0]         slv_BREADY,
    output logic [$clog2(DEPTH):0]     out_cnt,
    output logic                       multi_grant_err
);

    localparam int c_IDX_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_PTR_W  = c_ADDR_W + 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_PTR_W-1:0] c_FULL    = c_PTR_W'(DEPTH);

    // In-order queue of slave indices, one entry per outstanding transaction
    logic [c_IDX_W-1:0] r_entry [DEPTH];

    // Pointers carry a wrap bit so that full and empty can be told apart
    logic [c_PTR_W-1:0] r_aw_ptr;
    logic [c_PTR_W-1:0] r_w_ptr;
    logic [c_PTR_W-1:0] r_b_ptr;
    logic               r_multi_err;

    logic [c_IDX_W-1:0] w_aw_idx;
    logic               w_match_any;
    logic               w_match_multi;
    logic               w_aw_hit;
    logic [c_PTR_W-1:0] w_cnt;
    logic               w_full;
    logic [c_IDX_W-1:0] w_w_head;
    logic [c_IDX_W-1:0] w_b_head;
    logic               w_w_pend;
    logic               w_b_pend;
    logic               w_aw_rdy_sel;
    logic               w_w_rdy_sel;
    logic               w_b_vld_sel;
    logic [1:0]         w_b_resp_sel;
    logic [NUM_SLV-1:0] w_w_oh;
    logic [NUM_SLV-1:0] w_b_oh;
    logic               w_aw_fire;
    logic               w_wlast_fire;
    logic               w_b_fire;

    // Grant decode: locate the slave carrying our code and flag any ambiguity
    always_comb begin
        w_aw_idx      = '0;
        w_match_any   = 1'b0;
        w_match_multi = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sl_mas_sel[i*SEL_W +: SEL_W] == MAS_CODE) begin
                if (w_match_any) begin
                    w_match_multi = 1'b1;
                end
                w_match_any = 1'b1;
                w_aw_idx    = c_IDX_W'(i);
            end
        end
    end

    assign w_aw_hit = w_match_any & ~w_match_multi;
    assign w_cnt    = r_aw_ptr - r_b_ptr;
    assign w_full   = (w_cnt == c_FULL);
    assign w_w_head = r_entry[r_w_ptr[c_ADDR_W-1:0]];
    assign w_b_head = r_entry[r_b_ptr[c_ADDR_W-1:0]];
    assign w_w_pend = (r_w_ptr != r_aw_ptr);
    assign w_b_pend = (r_b_ptr != r_w_ptr);

    // Per-slave return muxes for the AW target, the W head and the B head
    always_comb begin
        w_aw_rdy_sel = 1'b0;
        w_w_rdy_sel  = 1'b0;
        w_b_vld_sel  = 1'b0;
        w_b_resp_sel = 2'b00;
        w_w_oh       = '0;
        w_b_oh       = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (c_IDX_W'(i) == w_aw_idx) begin
                w_aw_rdy_sel = s_AWREADY[i];
            end
            if (c_IDX_W'(i) == w_w_head) begin
                w_w_rdy_sel = s_WREADY[i];
                w_w_oh[i]   = 1'b1;
            end
            if (c_IDX_W'(i) == w_b_head) begin
                w_b_vld_sel  = s_BVALID[i];
                w_b_resp_sel = s_BRESP[2*i +: 2];
                w_b_oh[i]    = 1'b1;
            end
        end
    end

    // Return path is combinational; everything is forced low during reset
    assign wr_AWREADY      = w_aw_hit & w_aw_rdy_sel & ~w_full & ~ARESET;
    assign wr_WREADY       = w_w_pend & w_w_rdy_sel & ~ARESET;
    assign slv_WSEL        = (w_w_pend & ~ARESET) ? w_w_oh : '0;
    assign wr_BVALID       = w_b_pend & w_b_vld_sel & ~ARESET;
    assign wr_BRESP        = wr_BVALID ? w_b_resp_sel : 2'b00;
    assign slv_BREADY      = (w_b_pend & mst_BREADY & ~ARESET) ? w_b_oh : '0;
    assign out_cnt         = ARESET ? '0 : w_cnt;
    assign multi_grant_err = r_multi_err & ~ARESET;

    assign w_aw_fire    = mst_AWVALID & wr_AWREADY;
    assign w_wlast_fire = mst_WVALID & wr_WREADY & mst_WLAST;
    assign w_b_fire     = wr_BVALID & mst_BREADY;

    // Queue storage: record the target slave at each AW handshake
    always_ff @(posedge ACLK) begin
        if (w_aw_fire) begin
            r_entry[r_aw_ptr[c_ADDR_W-1:0]] <= w_aw_idx;
        end
    end

    // Pointer advance and sticky multi-grant flag
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_aw_ptr    <= '0;
            r_w_ptr     <= '0;
            r_b_ptr     <= '0;
            r_multi_err <= 1'b0;
        end else begin
            if (w_aw_fire) begin
                r_aw_ptr <= r_aw_ptr + c_PTR_ONE;
            end
            if (w_wlast_fire) begin
                r_w_ptr <= r_w_ptr + c_PTR_ONE;
            end
            if (w_b_fire) begin
                r_b_ptr <= r_b_ptr + c_PTR_ONE;
            end
            if (w_match_multi) begin
                r_multi_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wr_resp_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_wr_resp_router
// Description : Scoreboard bench for wr_resp_router (4 slaves, depth 4).
//               The driver computes the expected outputs from a queue-level
//               reference model and pushes them. The monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wr_resp_router;

    localparam int NS = 4;
    localparam int DP = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       awvalid, wvalid, wlast, bready;
    logic [7:0] sel;
    logic [3:0] s_awr, s_wr, s_bv;
    logic [7:0] s_br;
    logic       o_awready, o_wready, o_bvalid;
    logic [1:0] o_bresp;
    logic [3:0] o_wsel, o_bready;
    logic [2:0] o_cnt;
    logic       o_merr;

    typedef struct {
        logic       awready;
        logic       wready;
        logic       bvalid;
        logic [1:0] bresp;
        logic [3:0] wsel;
        logic [3:0] bready;
        logic [2:0] cnt;
        logic       merr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: transactions awaiting WLAST, then transactions awaiting B
    int   m_wq[$];
    int   m_bq[$];
    bit   m_err;

    always #5 clk = ~clk;

    wr_resp_router #(
        .NUM_SLV (NS),
        .SEL_W   (2),
        .MAS_CODE(2'b01),
        .DEPTH   (DP)
    ) dut (
        .ACLK           (clk),
        .ARESET         (rst),
        .mst_AWVALID    (awvalid),
        .mst_WVALID     (wvalid),
        .mst_WLAST      (wlast),
        .mst_BREADY     (bready),
        .sl_mas_sel     (sel),
        .s_AWREADY      (s_awr),
        .s_WREADY       (s_wr),
        .s_BVALID       (s_bv),
        .s_BRESP        (s_br),
        .wr_AWREADY     (o_awready),
        .wr_WREADY      (o_wready),
        .wr_BVALID      (o_bvalid),
        .wr_BRESP       (o_bresp),
        .slv_WSEL       (o_wsel),
        .slv_BREADY     (o_bready),
        .out_cnt        (o_cnt),
        .multi_grant_err(o_merr)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", nm, $time, act, expv);
        end
    endtask

    function automatic logic [7:0] sel_for(input int s);
        logic [7:0] v;
        v = 8'h00;
        v[2*s +: 2] = 2'b01;
        return v;
    endfunction

    // One cycle: drive inputs, predict outputs, push prediction, advance model
    task automatic cycle(input logic r, input logic awv, input logic wv, input logic wl,
                         input logic br, input logic [7:0] sl, input logic [3:0] awr,
                         input logic [3:0] wr, input logic [3:0] bv, input logic [7:0] bresp);
        exp_t e;
        int   nmatch;
        int   idx;
        int   cnt;
        @(negedge clk);
        rst = r; awvalid = awv; wvalid = wv; wlast = wl; bready = br;
        sel = sl; s_awr = awr; s_wr = wr; s_bv = bv; s_br = bresp;

        nmatch = 0;
        idx    = 0;
        for (int j = 0; j < NS; j++) begin
            if (sl[2*j +: 2] == 2'b01) begin
                nmatch++;
                idx = j;
            end
        end
        cnt = m_wq.size() + m_bq.size();

        e.awready = !r && (nmatch == 1) && awr[idx] && (cnt != DP);
        e.wready  = !r && (m_wq.size() > 0) && wr[m_wq[0]];
        e.wsel    = (!r && m_wq.size() > 0) ? 4'(1 << m_wq[0]) : 4'h0;
        e.bvalid  = !r && (m_bq.size() > 0) && bv[m_bq[0]];
        e.bresp   = e.bvalid ? bresp[2*m_bq[0] +: 2] : 2'b00;
        e.bready  = (!r && m_bq.size() > 0 && br) ? 4'(1 << m_bq[0]) : 4'h0;
        e.cnt     = r ? 3'd0 : 3'(cnt);
        e.merr    = r ? 1'b0 : m_err;
        exp_q.push_back(e);

        if (r) begin
            m_wq.delete();
            m_bq.delete();
            m_err = 1'b0;
        end else begin
            if (nmatch > 1) m_err = 1'b1;
            if (e.bvalid && br) void'(m_bq.pop_front());
            if (wv && e.wready && wl) m_bq.push_back(m_wq.pop_front());
            if (awv && e.awready) m_wq.push_back(idx);
        end
    endtask

    // Monitor: compare DUT outputs against the queued prediction mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("awready", {7'd0, o_awready}, {7'd0, e.awready});
                chk("wready",  {7'd0, o_wready},  {7'd0, e.wready});
                chk("wsel",    {4'd0, o_wsel},    {4'd0, e.wsel});
                chk("bvalid",  {7'd0, o_bvalid},  {7'd0, e.bvalid});
                chk("bresp",   {6'd0, o_bresp},   {6'd0, e.bresp});
                chk("bready",  {4'd0, o_bready},  {4'd0, e.bready});
                chk("out_cnt", {5'd0, o_cnt},     {5'd0, e.cnt});
                chk("merr",    {7'd0, o_merr},    {7'd0, e.merr});
            end
        end
    end

    initial begin
        logic [7:0] rs;
        int         s;
        int         k;
        rst = 1'b1; awvalid = 0; wvalid = 0; wlast = 0; bready = 0;
        sel = 0; s_awr = 0; s_wr = 0; s_bv = 0; s_br = 0;
        m_err = 1'b0;

        // Reset, then single AW to slave 2, its WLAST and its B
        cycle(1, 0, 0, 0, 0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h00);
        cycle(1, 0, 0, 0, 0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h00);
        cycle(0, 1, 0, 0, 0, sel_for(2), 4'hF, 4'h0, 4'h0, 8'h00);
        cycle(0, 0, 1, 1, 0, 8'h00, 4'h0, 4'hF, 4'h0, 8'h00);
        cycle(0, 0, 0, 0, 1, 8'h00, 4'h0, 4'h0, 4'hF, 8'b00_10_00_00);

        // Fill with slaves 1,3,0,2, fifth AW must stall
        cycle(0, 1, 0, 0, 0, sel_for(1), 4'hF, 4'h0, 4'h0, 8'h00);
        cycle(0, 1, 0, 0, 0, sel_for(3), 4'hF, 4'h0, 4'h0, 8'h00);
        cycle(0, 1, 0, 0, 0, sel_for(0), 4'hF, 4'h0, 4'h0, 8'h00);
        cycle(0, 1, 0, 0, 0, sel_for(2), 4'hF, 4'h0, 4'h0, 8'h00);
        cycle(0, 1, 0, 0, 0, sel_for(1), 4'hF, 4'h0, 4'h0, 8'h00);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 1, 0, 8'h00, 4'h0, 4'hF, 4'h0, 8'h00);
        // Non-head slave 3 response is held off
        cycle(0, 0, 0, 0, 1, 8'h00, 4'h0, 4'h0, 4'b1000, 8'hFF);
        // Full: B pop and AW in the same cycle, AW accepted only next cycle
        cycle(0, 1, 0, 0, 1, sel_for(0), 4'hF, 4'h0, 4'hF, 8'h1B);
        cycle(0, 1, 0, 0, 0, sel_for(0), 4'hF, 4'h0, 4'h0, 8'h00);

        // AW and WLAST in the same cycle, early BVALID ignored
        cycle(1, 0, 0, 0, 0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h00);
        cycle(0, 1, 1, 1, 0, sel_for(3), 4'hF, 4'hF, 4'hF, 8'hC0);
        cycle(0, 0, 1, 1, 1, 8'h00, 4'h0, 4'hF, 4'hF, 8'hC0);
        cycle(0, 0, 0, 0, 1, 8'h00, 4'h0, 4'h0, 4'hF, 8'hC0);

        // Double grant: no AWREADY, sticky error until reset
        cycle(0, 1, 0, 0, 0, 8'b00_00_01_01, 4'hF, 4'h0, 4'h0, 8'h00);
        cycle(0, 1, 0, 0, 0, sel_for(1), 4'hF, 4'h0, 4'h0, 8'h00);
        cycle(0, 0, 0, 0, 0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h00);

        // Reset with two outstanding and BVALID high
        cycle(0, 1, 0, 0, 0, sel_for(2), 4'hF, 4'h0, 4'h0, 8'h00);
        cycle(0, 0, 1, 1, 0, 8'h00, 4'h0, 4'hF, 4'h0, 8'h00);
        cycle(1, 0, 0, 0, 1, 8'h00, 4'hF, 4'hF, 4'hF, 8'hFF);
        cycle(0, 0, 0, 0, 1, 8'h00, 4'h0, 4'h0, 4'hF, 8'hFF);

        // Randomised traffic
        for (int n = 0; n < 4000; n++) begin
            k = $urandom_range(0, 49);
            if (k == 0) begin
                rs = 8'($urandom);
            end else if (k == 1) begin
                rs = 8'b01_01_00_00;
            end else begin
                s  = $urandom_range(0, NS - 1);
                rs = 8'h00;
                for (int j = 0; j < NS; j++) begin
                    int r3;
                    r3 = $urandom_range(0, 2);
                    rs[2*j +: 2] = (j == s) ? 2'b01 : ((r3 == 0) ? 2'b00 : 2'(r3 + 1));
                end
            end
            cycle($urandom_range(0, 299) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
                  rs, 4'($urandom), 4'($urandom), 4'($urandom), 8'($urandom));
        end

        @(negedge clk);
        #5;
        chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
